// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: fetch state encoding, F/D bundle widths
// and reset/bubble defaults.
package rv32_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam int FD_INSTR_W = 32;
  localparam int FD_PC_W    = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  // Sequential word address; wraps at the top of the address space.
  function automatic logic [FD_PC_W-1:0] nextWordPc(input logic [FD_PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_cycle_chk.sv
// Protocol checker for the fetch stage's instruction-memory interface.
module fetch_cycle_chk
  import rv32_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input fetchState_e state,
  input logic        imemReq,
  input logic        imemGnt,
  input logic        imemRvalid
);

  logic armed_r;

  // Responses before the first post-reset grant belong to pre-reset traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r <= 1'b0;
    end else if (imemReq && imemGnt) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  rvalidOnlyInWait: assert property (@(posedge clk) disable iff (rst)
    (armed_r && imemRvalid) |-> (state == WAIT))
    else $error("imem_rvalid seen with no request outstanding");

endmodule

// File: rtl/fetch_skid_reg.sv
// One-entry {instr, pc} holding register that absorbs a response while decode
// is stalled; presents pc+4 alongside the held PC.
module fetch_skid_reg
  import rv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [FD_INSTR_W-1:0] instrIn,
  input  logic [FD_PC_W-1:0]    pcIn,
  output logic                  valid,
  output logic [FD_INSTR_W-1:0] instr,
  output logic [FD_PC_W-1:0]    pc,
  output logic [FD_PC_W-1:0]    pcPlus4
);

  logic                  valid_r;
  logic [FD_INSTR_W-1:0] instr_r;
  logic [FD_PC_W-1:0]    pc_r;

  // Holding register; clear takes priority over load.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_r <= 1'b0;
      instr_r <= '0;
      pc_r    <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= instrIn;
      pc_r    <= pcIn;
    end else begin
      valid_r <= valid_r;
      instr_r <= instr_r;
      pc_r    <= pc_r;
    end
  end

  assign valid   = valid_r;
  assign instr   = instr_r;
  assign pc      = pc_r;
  assign pcPlus4 = nextWordPc(pc_r);

endmodule

// File: rtl/fetch_cycle.sv
// RV32I instruction-fetch stage: owns the PC, runs a single-outstanding
// imem request/response port and drives the F/D pipeline register.
module fetch_cycle
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] PCF
);

  fetchState_e state_r, stateNext_s;
  logic [31:0] pcF_r, pcNext_s, pcPlus4F_s, pcTarget_s;
  logic        drop_r, dropNext_s;
  logic        fdLoad_s, fdSkid_s, fdBubble_s, skidLoad_s, skidClear_s;
  logic        imemReq_s;
  logic [31:0] imemAddr_s;
  logic        skidValid_s;
  logic [31:0] skidInstr_s, skidPc_s, skidPcPlus4_s;
  logic [31:0] instrD_r, pcD_r, pcPlus4D_r;
  logic        validD_r;

  assign pcPlus4F_s = nextWordPc(pcF_r);
  assign pcTarget_s = PCTargetE & 32'hFFFF_FFFC;

  // Next-state, PC update and request generation; a redirect overrides everything.
  always_comb begin
    stateNext_s = state_r;
    pcNext_s    = pcF_r;
    dropNext_s  = drop_r;
    fdLoad_s    = 1'b0;
    fdSkid_s    = 1'b0;
    skidLoad_s  = 1'b0;
    skidClear_s = 1'b0;
    imemReq_s   = 1'b0;
    imemAddr_s  = pcF_r;
    if (PCSrcE) begin
      pcNext_s    = pcTarget_s;
      skidClear_s = 1'b1;
      case (state_r)
        REQ: begin
          // The request already on the bus stays up; if taken it becomes stale.
          imemReq_s = 1'b1;
          if (imem_gnt) begin
            stateNext_s = WAIT;
            dropNext_s  = 1'b1;
          end else begin
            stateNext_s = REQ;
            dropNext_s  = 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            stateNext_s = REQ;
            dropNext_s  = 1'b0;
          end else begin
            stateNext_s = WAIT;
            dropNext_s  = 1'b1;
          end
        end
        default: begin
          stateNext_s = REQ;
          dropNext_s  = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        REQ: begin
          imemReq_s = 1'b1;
          if (imem_gnt) begin
            stateNext_s = WAIT;
          end else begin
            stateNext_s = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid && drop_r) begin
            dropNext_s  = 1'b0;
            stateNext_s = REQ;
          end else if (imem_rvalid && !StallD) begin
            // Issue the follow-on fetch in the same cycle for 1 instr/cycle.
            fdLoad_s    = 1'b1;
            pcNext_s    = pcPlus4F_s;
            imemReq_s   = 1'b1;
            imemAddr_s  = pcPlus4F_s;
            stateNext_s = imem_gnt ? WAIT : REQ;
          end else if (imem_rvalid) begin
            skidLoad_s  = 1'b1;
            pcNext_s    = pcPlus4F_s;
            stateNext_s = HOLD;
          end else begin
            stateNext_s = WAIT;
          end
        end
        HOLD: begin
          if (!StallD) begin
            fdSkid_s    = skidValid_s;
            stateNext_s = REQ;
          end else begin
            stateNext_s = HOLD;
          end
        end
        default: begin
          stateNext_s = REQ;
        end
      endcase
    end
  end

  // When decode consumes F/D and nothing new arrives, a bubble takes its place.
  assign fdBubble_s = PCSrcE || (!StallD && !fdLoad_s && !fdSkid_s);

  // Fetch control state and PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= REQ;
      pcF_r   <= RESET_PC;
      drop_r  <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      pcF_r   <= pcNext_s;
      drop_r  <= dropNext_s;
    end
  end

  // F/D pipeline register.
  always_ff @(posedge clk) begin
    if (rst || fdBubble_s) begin
      instrD_r   <= NOP_INSTR;
      pcD_r      <= 32'h0000_0000;
      pcPlus4D_r <= 32'h0000_0000;
      validD_r   <= 1'b0;
    end else if (fdLoad_s) begin
      instrD_r   <= imem_rdata;
      pcD_r      <= pcF_r;
      pcPlus4D_r <= pcPlus4F_s;
      validD_r   <= 1'b1;
    end else if (fdSkid_s) begin
      instrD_r   <= skidInstr_s;
      pcD_r      <= skidPc_s;
      pcPlus4D_r <= skidPcPlus4_s;
      validD_r   <= 1'b1;
    end else begin
      instrD_r   <= instrD_r;
      pcD_r      <= pcD_r;
      pcPlus4D_r <= pcPlus4D_r;
      validD_r   <= validD_r;
    end
  end

  fetch_skid_reg uSkid (
    .clk     (clk),
    .rst     (rst),
    .load    (skidLoad_s),
    .clear   (skidClear_s || fdSkid_s),
    .instrIn (imem_rdata),
    .pcIn    (pcF_r),
    .valid   (skidValid_s),
    .instr   (skidInstr_s),
    .pc      (skidPc_s),
    .pcPlus4 (skidPcPlus4_s)
  );

  fetch_cycle_chk uChk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .imemReq    (imemReq_s),
    .imemGnt    (imem_gnt),
    .imemRvalid (imem_rvalid)
  );

  assign imem_req  = imemReq_s;
  assign imem_addr = imemAddr_s;
  assign InstrD    = instrD_r;
  assign PCD       = pcD_r;
  assign PCPlus4D  = pcPlus4D_r;
  assign ValidD    = validD_r;
  assign PCF       = pcF_r;

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed vector table, reset/wrap sequences, and
// randomized traffic against a transaction-level model.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst, StallD, PCSrcE, imem_gnt, imem_rvalid, imem_req, ValidD;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D, PCF;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_cycle dut (
    .clk(clk), .rst(rst), .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCF(PCF)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0FF_EE00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        pcSrc;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdAddr;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPcD;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                              input logic g, input logic r, input logic [31:0] ra,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.pcSrc = p; v.tgt = t; v.gnt = g; v.rv = r; v.rdAddr = ra;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPcD = ep;
    return v;
  endfunction

  task automatic chkFd(input string tag, input logic ev, input logic [31:0] ep);
    chk({tag, ".ValidD"}, ValidD, ev);
    chk({tag, ".PCD"}, PCD, ev ? ep : 32'h0);
    chk({tag, ".PCPlus4D"}, PCPlus4D, ev ? ep + 32'd4 : 32'h0);
    chk({tag, ".InstrD"}, InstrD, ev ? memWord(ep) : NOP);
  endtask

  task automatic doReset();
    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.InstrD", InstrD, NOP);
    chk("rst.PCD", PCD, 32'h0);
    chk("rst.PCPlus4D", PCPlus4D, 32'h0);
    chk("rst.ValidD", ValidD, 1'b0);
    chk("rst.PCF", PCF, 32'h0);
    rst = 1'b0;
  endtask

  // Reference model state: outstanding request, staleness, skid entry, PC, F/D.
  logic        mOut, mStale, mSkid, took, eReq, accepted;
  logic [31:0] mPc, mSkidInstr, mSkidPc, eAddr;
  logic        eValid;
  logic [31:0] eInstr, ePcD, ePlus4;
  logic        memBusy;
  logic [31:0] memAddr;
  int          memDelay;

  task automatic bubble();
    eInstr = NOP; ePcD = 32'h0; ePlus4 = 32'h0; eValid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h4,         1, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0,         0, 1, 32'h4,         0, 32'h0,         1, 32'h0);
    vecs[4]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h0);
    vecs[5]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h4);
    vecs[6]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         0, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,         1, 1, 32'h8,         1, 32'hC,         1, 32'h8);
    vecs[8]  = mk(0, 1, 32'h103,       0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vecs[9]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,         0, 1, 32'hC,         0, 32'h0,         0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,         1, 1, 32'h100,       1, 32'h104,       1, 32'h100);
    vecs[13] = mk(0, 1, 32'h200,       1, 1, 32'h104,       0, 32'h0,         0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,         0, 1, 32'h200,       1, 32'h204,       1, 32'h200);
    vecs[16] = mk(0, 1, 32'hFFFF_FFFF, 0, 0, 32'h0,         1, 32'h204,       0, 32'h0);
    vecs[17] = mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'h0,         1, 32'hFFFF_FFFC);
    vecs[19] = mk(0, 0, 32'h0,         0, 1, 32'h0,         1, 32'h4,         1, 32'h0);

    doReset();

    // Directed table: stall/skid, redirect in WAIT, redirect with rvalid, wrap.
    for (int i = 0; i < 20; i++) begin
      StallD = vecs[i].stall; PCSrcE = vecs[i].pcSrc; PCTargetE = vecs[i].tgt;
      imem_rvalid = vecs[i].rv; imem_rdata = memWord(vecs[i].rdAddr);
      imem_gnt = vecs[i].gnt;
      #1;
      chk($sformatf("vec%0d.req", i), imem_req, vecs[i].expReq);
      if (vecs[i].expReq) chk($sformatf("vec%0d.addr", i), imem_addr, vecs[i].expAddr);
      @(negedge clk);
      chkFd($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPcD);
    end

    // Reset while a request is outstanding; the late response must be ignored.
    StallD = 1'b0; PCSrcE = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b0;
    @(negedge clk);
    chkFd("midrst", 1'b0, 32'h0);
    chk("midrst.PCF", PCF, 32'h0);
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = memWord(32'h4);
    #1;
    chk("midrst.req", imem_req, 1'b1);
    chk("midrst.addr", imem_addr, 32'h0);
    @(negedge clk);
    chkFd("late", 1'b0, 32'h0);
    chk("late.PCF", PCF, 32'h0);
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    #1;
    chk("postrst.addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = memWord(32'h0);
    @(negedge clk);
    chkFd("postrst", 1'b1, 32'h0);
    chk("postrst.PCF", PCF, 32'h4);
    imem_rvalid = 1'b0;

    // Randomized traffic against the transaction-level model.
    doReset();
    mPc = 32'h0; mOut = 1'b0; mStale = 1'b0; mSkid = 1'b0;
    mSkidInstr = 32'h0; mSkidPc = 32'h0;
    bubble();
    memBusy = 1'b0; memAddr = 32'h0; memDelay = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      StallD = ($urandom % 4) == 0;
      PCSrcE = ($urandom % 12) == 0;
      PCTargetE = $urandom;
      imem_rvalid = memBusy && (memDelay == 0);
      imem_rdata = memBusy ? memWord(memAddr) : $urandom;
      eAddr = mPc;
      if (mSkid) begin
        eReq = 1'b0;
      end else if (mOut) begin
        eReq = imem_rvalid && !mStale && !StallD && !PCSrcE;
        eAddr = mPc + 32'd4;
      end else begin
        eReq = 1'b1;
      end
      #1;
      chk("rnd.req", imem_req, eReq);
      if (eReq) chk("rnd.addr", imem_addr, eAddr);
      imem_gnt = eReq && (($urandom % 3) != 0);
      accepted = eReq && imem_gnt;

      if (PCSrcE) begin
        bubble();
        mSkid = 1'b0;
        if (mOut) begin
          if (imem_rvalid) mOut = 1'b0;
          else mStale = 1'b1;
        end else if (accepted) begin
          mOut = 1'b1; mStale = 1'b1;
        end
        mPc = PCTargetE & 32'hFFFF_FFFC;
      end else begin
        took = 1'b0;
        if (mOut && imem_rvalid) begin
          if (mStale) begin
            mStale = 1'b0;
          end else if (!StallD) begin
            eInstr = imem_rdata; ePcD = mPc; ePlus4 = mPc + 32'd4; eValid = 1'b1;
            took = 1'b1; mPc = mPc + 32'd4;
          end else begin
            mSkid = 1'b1; mSkidInstr = imem_rdata; mSkidPc = mPc; mPc = mPc + 32'd4;
          end
          mOut = 1'b0;
        end else if (mSkid && !StallD) begin
          eInstr = mSkidInstr; ePcD = mSkidPc; ePlus4 = mSkidPc + 32'd4; eValid = 1'b1;
          mSkid = 1'b0; took = 1'b1;
        end
        if (!StallD && !took) bubble();
        if (accepted) begin
          mOut = 1'b1; mStale = 1'b0;
        end
      end

      if (imem_rvalid) memBusy = 1'b0;
      else if (memBusy) memDelay--;
      if (accepted) begin
        memBusy = 1'b1; memAddr = eAddr; memDelay = $urandom % 3;
      end

      @(negedge clk);
      chk("rnd.ValidD", ValidD, eValid);
      chk("rnd.PCD", PCD, ePcD);
      chk("rnd.PCPlus4D", PCPlus4D, ePlus4);
      chk("rnd.InstrD", InstrD, eInstr);
      chk("rnd.PCF", PCF, mPc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC register and drives a request/response instruction-memory interface with at most one outstanding request.
- Absorbs decode back-pressure through a one-entry skid buffer and redirects on taken branches and jumps resolved in execute.
- Produces the F/D pipeline register: InstrD, PCD, PCPlus4D, ValidD.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on InstrD when invalid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StallD  in  1  decode cannot accept; hold F/D.
- PCSrcE  in  1  redirect from execute (taken branch, jal, jalr); also flushes F/D.
- PCTargetE  in  32  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  request valid.
- imem_addr  out  32  word address of the request.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- InstrD  out  32  F/D instruction.
- PCD  out  32  F/D PC.
- PCPlus4D  out  32  F/D PC+4.
- ValidD  out  1  F/D holds a real instruction.
- PCF  out  32  current fetch PC (debug and hazard unit).

Behaviour:
- Reset (rst=1 at an edge, overrides everything, including mid-transaction):
  - pc_f=RESET_PC; state=REQ; skid and drop flag cleared.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - A response arriving after reset for a pre-reset request is ignored.
- States:
  - REQ: no request outstanding.
  - WAIT: one request outstanding.
  - HOLD: response captured in the skid buffer, decode stalled.
- REQ:
  - imem_req=1, imem_addr=pc_f.
  - gnt → WAIT; no gnt → stay in REQ with the request held stable.
- WAIT, rvalid and drop=0:
  - StallD=0: F/D <= {rdata, pc_f, pc_f+4, 1}; pc_f <= pc_f+4.
    - In the same cycle, imem_req=1 with imem_addr=pc_f+4. gnt → stay in WAIT, else → REQ.
    - Gives back-to-back throughput of 1 instruction/cycle with a 1-cycle-latency memory.
  - StallD=1: skid <= {rdata, pc_f}; pc_f <= pc_f+4; → HOLD.
- WAIT, rvalid and drop=1: discard the response, clear drop, → REQ. pc_f is already the redirect target.
- HOLD:
  - imem_req=0.
  - When StallD=0: F/D <= skid contents with ValidD=1, → REQ.
- F/D holds its value whenever StallD=1 and no redirect is present.
- ValidD=0 whenever F/D is loaded with a bubble.
- Redirect (PCSrcE=1) has priority over StallD, rvalid and gnt:
  - pc_f <= {PCTargetE[31:2],2'b00}.
  - F/D <= {NOP_INSTR, 0, 0, 0}.
  - Skid is cleared.
  - No new request is issued that cycle.
  - Next state:
    - WAIT with rvalid=0 → WAIT with drop=1.
    - WAIT with rvalid=1 → response discarded, → REQ.
    - REQ with gnt=1 in the same cycle → WAIT with drop=1.
    - HOLD → REQ.
- Arithmetic: PC+4 is a 32-bit add with wrap-around; 32'hFFFF_FFFC+4 = 0.
- Invariants:
  - At most one request is outstanding.
  - imem_rvalid in REQ or HOLD is a protocol error, ignored, and flagged by a simulation assertion.

Decomposition:
- Shared package rv32_pkg holds:
  - NOP_INSTR and RESET_PC defaults;
  - fetch state encoding (REQ=2'd0, WAIT=2'd1, HOLD=2'd2);
  - the F/D bundle field widths.
- One sub-module, fetch_skid_reg:
  - one-entry {instr, pc} holding register with load, clear and valid;
  - computes pc+4 on read-out.

Test Plan:
- Reset, then gnt tied to 1 and rvalid one cycle after each gnt:
  - ValidD stays 0 until the first response.
  - PCD then steps 0x0, 0x4, 0x8, … one per cycle.
  - InstrD matches the memory model and PCPlus4D = PCD+4.
- StallD=1 for 3 cycles while a response lands:
  - F/D unchanged throughout.
  - Response held in HOLD with imem_req=0.
  - The instruction appears on InstrD in the first cycle after StallD=0, with no duplicate or skipped PC.
- PCSrcE=1, PCTargetE=0x0000_0103 while in WAIT, rvalid two cycles later:
  - F/D becomes NOP_INSTR with ValidD=0.
  - The stale response is discarded.
  - The next imem_addr is 0x100.
- PCSrcE=1 in the same cycle as rvalid:
  - The response is dropped.
  - PCD never shows the dropped PC.
  - The next request goes to the target.
- rst=1 asserted while in WAIT:
  - All outputs return to reset values.
  - A late rvalid is ignored.
  - The first request after reset is to RESET_PC.
- Start with pc_f at 0xFFFF_FFFC: PCPlus4D = 0x0 and the next imem_addr = 0x0.
